// File: rtl/lock_sequencer_if.sv
// Bus between the pound-lock sequencer and the lock top level: gondola
// requests, gate status, gate open strobes, water movement and status.
interface lock_sequencer_if #(
   parameter int LEVEL_MAX = 8
);

   localparam int LevelW = $clog2(LEVEL_MAX + 1);

   // Gondola requests and gate status into the sequencer
   logic              req_up;
   logic              req_down;
   logic              gate_up_closed;
   logic              gate_down_closed;

   // Gate strobes, water control and status out of the sequencer
   logic              open_up;
   logic              open_down;
   logic              fill;
   logic              drain;
   logic [LevelW-1:0] level;
   logic              busy;
   logic              ack_up;
   logic              ack_down;

   // Lock top level / environment side
   modport master (
      output req_up,
      output req_down,
      output gate_up_closed,
      output gate_down_closed,
      input  open_up,
      input  open_down,
      input  fill,
      input  drain,
      input  level,
      input  busy,
      input  ack_up,
      input  ack_down
   );

   // Sequencer side
   modport slave (
      input  req_up,
      input  req_down,
      input  gate_up_closed,
      input  gate_down_closed,
      output open_up,
      output open_down,
      output fill,
      output drain,
      output level,
      output busy,
      output ack_up,
      output ack_down
   );

endinterface

// File: rtl/lock_sequencer.sv
// Pound-lock chamber sequencer. Serves one gondola at a time through
// IDLE -> PREP -> ENTER -> SHIFT -> EXIT, moving the modeled water level one
// step per cycle only while both gates report closed.
module lock_sequencer #(
   parameter int LEVEL_MAX   = 8,
   parameter int PASS_CYCLES = 4
) (
   input logic             clk,
   input logic             reset,
   lock_sequencer_if.slave bus
);

   localparam int LevelW = $clog2(LEVEL_MAX + 1);
   localparam int CntW   = (PASS_CYCLES > 1) ? $clog2(PASS_CYCLES) : 1;

   localparam logic [LevelW-1:0] LevelTop = LevelW'(LEVEL_MAX);
   localparam logic [CntW-1:0]   CntLast  = CntW'(PASS_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StPrep,
      StEnter,
      StShift,
      StExit
   } state_t;

   // Side a gondola enters from; SideUp = upstream (downbound traffic)
   typedef enum logic {
      SideDown = 1'b0,
      SideUp   = 1'b1
   } side_t;

   state_t            stateQ, stateD;
   side_t             dirQ, dirD;
   side_t             lastServedQ, lastServedD;
   logic [LevelW-1:0] levelQ, levelD;
   logic [CntW-1:0]   cntQ, cntD;
   logic              ackUpQ, ackUpD;
   logic              ackDownQ, ackDownD;

   logic [LevelW-1:0] target;
   side_t             grant;
   logic              gatesClosed;
   logic              entryClosed;
   logic              exitClosed;
   logic              moving;
   logic              fillNow;
   logic              drainNow;
   logic              dwellDone;

   assign gatesClosed = bus.gate_up_closed & bus.gate_down_closed;
   assign entryClosed = (dirQ == SideUp) ? bus.gate_up_closed : bus.gate_down_closed;
   assign exitClosed  = (dirQ == SideUp) ? bus.gate_down_closed : bus.gate_up_closed;
   assign dwellDone   = (cntQ == CntLast);

   // Water level the chamber must reach before the next gate may open
   always_comb begin
      target = '0;
      if (stateQ == StPrep) begin
         target = (dirQ == SideUp) ? LevelTop : '0;
      end else if (stateQ == StShift) begin
         target = (dirQ == SideUp) ? '0 : LevelTop;
      end
   end

   // Water moves only in PREP/SHIFT with both gates shut; saturate at the ends
   always_comb begin
      moving   = ((stateQ == StPrep) || (stateQ == StShift)) && gatesClosed;
      fillNow  = moving && (levelQ < target) && (levelQ != LevelTop);
      drainNow = moving && (levelQ > target) && (levelQ != '0);
   end

   // Arbitration between two waiting gondolas
   always_comb begin
      grant = SideDown;
      if (bus.req_up && bus.req_down) begin
         if (levelQ == '0) begin
            grant = SideDown;
         end else if (levelQ == LevelTop) begin
            grant = SideUp;
         end else begin
            grant = (lastServedQ == SideUp) ? SideDown : SideUp;
         end
      end else if (bus.req_up) begin
         grant = SideUp;
      end
   end

   // Next-state logic for the transaction sequence, level and dwell counter
   always_comb begin
      stateD      = stateQ;
      dirD        = dirQ;
      lastServedD = lastServedQ;
      levelD      = levelQ;
      cntD        = cntQ;
      ackUpD      = 1'b0;
      ackDownD    = 1'b0;

      if (fillNow) begin
         levelD = levelQ + 1'b1;
      end else if (drainNow) begin
         levelD = levelQ - 1'b1;
      end

      case (stateQ)
         StIdle: begin
            cntD = '0;
            // The ack cycle itself does not grant; a new grant follows it
            if (!ackUpQ && !ackDownQ && (bus.req_up || bus.req_down)) begin
               dirD        = grant;
               lastServedD = grant;
               stateD      = StPrep;
            end
         end
         StPrep: begin
            if (levelQ == target) begin
               stateD = StEnter;
               cntD   = '0;
            end
         end
         StEnter: begin
            if (dwellDone) begin
               if (entryClosed) begin
                  stateD = StShift;
               end
            end else begin
               cntD = cntQ + 1'b1;
            end
         end
         StShift: begin
            if (levelQ == target) begin
               stateD = StExit;
               cntD   = '0;
            end
         end
         StExit: begin
            if (dwellDone) begin
               if (exitClosed) begin
                  stateD   = StIdle;
                  ackUpD   = (dirQ == SideUp);
                  ackDownD = (dirQ == SideDown);
               end
            end else begin
               cntD = cntQ + 1'b1;
            end
         end
         default: begin
            stateD = StIdle;
         end
      endcase
   end

   // State registers; reset aborts any transaction without an ack
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stateQ      <= StIdle;
         dirQ        <= SideDown;
         lastServedQ <= SideUp;
         levelQ      <= '0;
         cntQ        <= '0;
         ackUpQ      <= 1'b0;
         ackDownQ    <= 1'b0;
      end else begin
         stateQ      <= stateD;
         dirQ        <= dirD;
         lastServedQ <= lastServedD;
         levelQ      <= levelD;
         cntQ        <= cntD;
         ackUpQ      <= ackUpD;
         ackDownQ    <= ackDownD;
      end
   end

   // Output decode; open strobes only in the first cycle of ENTER/EXIT
   always_comb begin
      bus.open_up   = ((stateQ == StEnter) && (cntQ == '0) && (dirQ == SideUp)) ||
                      ((stateQ == StExit) && (cntQ == '0) && (dirQ == SideDown));
      bus.open_down = ((stateQ == StEnter) && (cntQ == '0) && (dirQ == SideDown)) ||
                      ((stateQ == StExit) && (cntQ == '0) && (dirQ == SideUp));
      bus.fill      = fillNow;
      bus.drain     = drainNow;
      bus.level     = levelQ;
      bus.busy      = (stateQ != StIdle);
      bus.ack_up    = ackUpQ;
      bus.ack_down  = ackDownQ;
   end

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer with hand-computed cycle timelines.
module tb_lock_sequencer;

   localparam int LEVEL_MAX   = 8;
   localparam int PASS_CYCLES = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   nChecks = 0;
   int   nFails  = 0;

   lock_sequencer_if #(.LEVEL_MAX(LEVEL_MAX)) bus ();

   lock_sequencer #(
      .LEVEL_MAX  (LEVEL_MAX),
      .PASS_CYCLES(PASS_CYCLES)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      bus.req_up = 1'b0;
      bus.req_down = 1'b0;
      bus.gate_up_closed = 1'b1;
      bus.gate_down_closed = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      bus.req_up = 1'b0;
      bus.req_down = 1'b0;
      bus.gate_up_closed = 1'b1;
      bus.gate_down_closed = 1'b1;
      reset = 1'b1;
      tick();
      tick();
      nChecks++;
      if ({bus.open_up, bus.open_down, bus.fill, bus.drain, bus.busy, bus.ack_up,
           bus.ack_down} !== 7'b0) begin
         nFails++;
         $display("FAIL reset_outputs: got %b want 0000000", {bus.open_up, bus.open_down,
                  bus.fill, bus.drain, bus.busy, bus.ack_up, bus.ack_down});
      end
      nChecks++;
      if (bus.level !== 4'd0) begin
         nFails++;
         $display("FAIL reset_level: got %0d want 0", bus.level);
      end
      bus.req_down = 1'b1;
      tick();
      nChecks++;
      if (bus.busy !== 1'b0) begin
         nFails++;
         $display("FAIL reset_holds_idle: busy got %b want 0", bus.busy);
      end
      bus.req_down = 1'b0;
      reset = 1'b0;
      tick();
      nChecks++;
      if ({bus.busy, bus.level} !== 5'b0) begin
         nFails++;
         $display("FAIL reset_release: busy/level got %b/%0d want 0/0", bus.busy, bus.level);
      end
   endtask

   // Upbound from level 0: enter at once, fill 8, exit upstream, ack_down
   task automatic test_fill_transaction();
      bus.req_down = 1'b1;
      tick();  // c1 PREP
      nChecks++;
      if ({bus.busy, bus.open_down} !== 2'b10) begin
         nFails++;
         $display("FAIL t1_prep: busy/open_down got %b/%b want 1/0", bus.busy, bus.open_down);
      end
      tick();  // c2 first ENTER cycle
      nChecks++;
      if ({bus.open_down, bus.open_up} !== 2'b10) begin
         nFails++;
         $display("FAIL t1_open_down: open_down/open_up got %b/%b want 1/0", bus.open_down,
                  bus.open_up);
      end
      bus.req_down = 1'b0;
      for (int i = 3; i <= 5; i++) begin
         tick();
         nChecks++;
         if ({bus.open_down, bus.fill, bus.level} !== 6'b0) begin
            nFails++;
            $display("FAIL t1_dwell c%0d: open_down/fill/level got %b/%b/%0d want 0/0/0", i,
                     bus.open_down, bus.fill, bus.level);
         end
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         nChecks++;
         if ({bus.fill, bus.drain, bus.level} !== {2'b10, 4'(i)}) begin
            nFails++;
            $display("FAIL t1_fill step %0d: fill/drain/level got %b/%b/%0d want 1/0/%0d", i,
                     bus.fill, bus.drain, bus.level, i);
         end
      end
      tick();  // c14
      nChecks++;
      if ({bus.fill, bus.level} !== 5'b0_1000) begin
         nFails++;
         $display("FAIL t1_full: fill/level got %b/%0d want 0/8", bus.fill, bus.level);
      end
      tick();  // c15 first EXIT cycle
      nChecks++;
      if ({bus.open_up, bus.open_down} !== 2'b10) begin
         nFails++;
         $display("FAIL t1_open_up: open_up/open_down got %b/%b want 1/0", bus.open_up,
                  bus.open_down);
      end
      for (int i = 16; i <= 18; i++) begin
         tick();
         nChecks++;
         if ({bus.busy, bus.ack_down, bus.open_up} !== 3'b100) begin
            nFails++;
            $display("FAIL t1_exit_dwell c%0d: busy/ack_down/open_up got %b/%b/%b want 1/0/0",
                     i, bus.busy, bus.ack_down, bus.open_up);
         end
      end
      tick();  // c19 ack
      nChecks++;
      if ({bus.ack_down, bus.ack_up, bus.busy, bus.level} !== 7'b100_1000) begin
         nFails++;
         $display("FAIL t1_ack: ack_down/ack_up/busy/level got %b/%b/%b/%0d want 1/0/0/8",
                  bus.ack_down, bus.ack_up, bus.busy, bus.level);
      end
      tick();  // c20
      nChecks++;
      if (bus.ack_down !== 1'b0) begin
         nFails++;
         $display("FAIL t1_ack_width: ack_down got %b want 0", bus.ack_down);
      end
   endtask

   // Upbound from level 8: drain 8 in PREP, then fill 8 in SHIFT
   task automatic test_drain_then_fill();
      int drains = 0;
      int fills = 0;
      int opensUp = 0;
      int opensDown = 0;
      int openDownAt = -1;
      int ackAt = -1;
      bus.req_down = 1'b1;
      for (int c = 1; c <= 45 && ackAt < 0; c++) begin
         tick();
         bus.req_down = 1'b0;
         nChecks++;
         if ((bus.open_up || bus.open_down) && (bus.fill || bus.drain)) begin
            nFails++;
            $display("FAIL t2_strobe_while_moving c%0d: open=%b%b fill/drain=%b%b want no overlap",
                     c, bus.open_up, bus.open_down, bus.fill, bus.drain);
         end
         nChecks++;
         if (bus.fill && bus.drain) begin
            nFails++;
            $display("FAIL t2_fill_and_drain c%0d: got 1/1 want not both", c);
         end
         if (bus.drain) drains++;
         if (bus.fill) fills++;
         if (bus.open_up) opensUp++;
         if (bus.open_down) begin
            opensDown++;
            if (openDownAt < 0) openDownAt = c;
         end
         if (bus.ack_down) ackAt = c;
      end
      nChecks++;
      if (openDownAt !== 10) begin
         nFails++;
         $display("FAIL t2_open_down_cycle: got %0d want 10", openDownAt);
      end
      nChecks++;
      if ({drains, fills} !== {32'd8, 32'd8}) begin
         nFails++;
         $display("FAIL t2_move_counts: drain/fill got %0d/%0d want 8/8", drains, fills);
      end
      nChecks++;
      if ({opensUp, opensDown} !== {32'd1, 32'd1}) begin
         nFails++;
         $display("FAIL t2_open_counts: up/down got %0d/%0d want 1/1", opensUp, opensDown);
      end
      nChecks++;
      if (ackAt !== 27) begin
         nFails++;
         $display("FAIL t2_ack_cycle: got %0d want 27", ackAt);
      end
      nChecks++;
      if (bus.level !== 4'd8) begin
         nFails++;
         $display("FAIL t2_end_level: got %0d want 8", bus.level);
      end
      tick();
   endtask

   // Both requests at level 8: UP first, then DOWN with no drain in its PREP
   task automatic test_arbitration();
      int ackAt = -1;
      int sawAckDown = 0;
      bus.req_up = 1'b1;
      bus.req_down = 1'b1;
      tick();  // c1
      tick();  // c2
      nChecks++;
      if ({bus.open_up, bus.open_down} !== 2'b10) begin
         nFails++;
         $display("FAIL t3_up_first: open_up/open_down got %b/%b want 1/0", bus.open_up,
                  bus.open_down);
      end
      bus.req_up = 1'b0;
      for (int c = 3; c <= 40 && ackAt < 0; c++) begin
         tick();
         if (bus.ack_up) ackAt = c;
         if (bus.ack_down) sawAckDown = 1;
      end
      nChecks++;
      if (ackAt !== 19) begin
         nFails++;
         $display("FAIL t3_ack_up_cycle: got %0d want 19", ackAt);
      end
      nChecks++;
      if ({bus.level, 1'(sawAckDown)} !== 5'b0) begin
         nFails++;
         $display("FAIL t3_after_up: level/ack_down_seen got %0d/%0d want 0/0", bus.level,
                  sawAckDown);
      end
      tick();  // c20 grant cycle for DOWN
      nChecks++;
      if (bus.busy !== 1'b0) begin
         nFails++;
         $display("FAIL t3_ack_gap: busy got %b want 0", bus.busy);
      end
      tick();  // c21 PREP for DOWN
      nChecks++;
      if ({bus.busy, bus.fill, bus.drain, bus.level} !== 7'b100_0000) begin
         nFails++;
         $display("FAIL t3_down_prep: busy/fill/drain/level got %b/%b/%b/%0d want 1/0/0/0",
                  bus.busy, bus.fill, bus.drain, bus.level);
      end
      tick();  // c22
      nChecks++;
      if (bus.open_down !== 1'b1) begin
         nFails++;
         $display("FAIL t3_down_open: open_down got %b want 1", bus.open_down);
      end
      bus.req_down = 1'b0;
      ackAt = -1;
      for (int c = 23; c <= 60 && ackAt < 0; c++) begin
         tick();
         if (bus.ack_down) ackAt = c;
      end
      nChecks++;
      if ({ackAt, bus.level} !== {32'd39, 4'd8}) begin
         nFails++;
         $display("FAIL t3_ack_down: cycle/level got %0d/%0d want 39/8", ackAt, bus.level);
      end
   endtask

   // Downstream gate reported open during SHIFT at level 3 freezes the fill
   task automatic test_interlock();
      int ackAt = -1;
      apply_reset();
      bus.req_down = 1'b1;
      tick();  // c1
      bus.req_down = 1'b0;
      repeat (8) tick();  // c9
      nChecks++;
      if ({bus.fill, bus.level} !== 5'b1_0011) begin
         nFails++;
         $display("FAIL t4_pre: fill/level got %b/%0d want 1/3", bus.fill, bus.level);
      end
      bus.gate_down_closed = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         nChecks++;
         if ({bus.busy, bus.fill, bus.drain, bus.level} !== 7'b100_0011) begin
            nFails++;
            $display("FAIL t4_hold %0d: busy/fill/drain/level got %b/%b/%b/%0d want 1/0/0/3", k,
                     bus.busy, bus.fill, bus.drain, bus.level);
         end
         tick();
      end
      nChecks++;
      if (bus.level !== 4'd3) begin
         nFails++;
         $display("FAIL t4_held_level: got %0d want 3", bus.level);
      end
      bus.gate_down_closed = 1'b1;
      #1;
      nChecks++;
      if (bus.fill !== 1'b1) begin
         nFails++;
         $display("FAIL t4_resume_fill: got %b want 1", bus.fill);
      end
      tick();
      nChecks++;
      if (bus.level !== 4'd4) begin
         nFails++;
         $display("FAIL t4_resume_level: got %0d want 4", bus.level);
      end
      for (int c = 0; c < 40 && ackAt < 0; c++) begin
         tick();
         if (bus.ack_down) ackAt = c;
      end
      nChecks++;
      if (ackAt < 0) begin
         nFails++;
         $display("FAIL t4_completes: ack_down not seen within 40 cycles, want one");
      end
   endtask

   // Reset during SHIFT at level 5 clears everything immediately, no ack
   task automatic test_reset_mid();
      int acks = 0;
      apply_reset();
      bus.req_down = 1'b1;
      tick();  // c1
      bus.req_down = 1'b0;
      repeat (10) tick();  // c11
      nChecks++;
      if ({bus.fill, bus.level} !== 5'b1_0101) begin
         nFails++;
         $display("FAIL t5_pre: fill/level got %b/%0d want 1/5", bus.fill, bus.level);
      end
      reset = 1'b1;
      #1;
      nChecks++;
      if ({bus.busy, bus.fill, bus.level} !== 6'b0) begin
         nFails++;
         $display("FAIL t5_async: busy/fill/level got %b/%b/%0d want 0/0/0", bus.busy,
                  bus.fill, bus.level);
      end
      tick();
      reset = 1'b0;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (bus.ack_up || bus.ack_down || bus.busy) acks++;
      end
      nChecks++;
      if (acks !== 0) begin
         nFails++;
         $display("FAIL t5_no_ack: ack/busy cycles got %0d want 0", acks);
      end
   endtask

   // Dropping req_up right after grant still completes with one ack_up
   task automatic test_drop_request();
      int ackAt = -1;
      int ackUps = 0;
      int ackDowns = 0;
      bus.req_up = 1'b1;
      tick();  // c1
      bus.req_up = 1'b0;
      nChecks++;
      if (bus.busy !== 1'b1) begin
         nFails++;
         $display("FAIL t6_granted: busy got %b want 1", bus.busy);
      end
      for (int c = 2; c <= 40; c++) begin
         tick();
         if (bus.ack_up) begin
            ackUps++;
            if (ackAt < 0) ackAt = c;
         end
         if (bus.ack_down) ackDowns++;
      end
      nChecks++;
      if ({ackUps, ackDowns} !== {32'd1, 32'd0}) begin
         nFails++;
         $display("FAIL t6_ack_counts: ack_up/ack_down got %0d/%0d want 1/0", ackUps, ackDowns);
      end
      nChecks++;
      if (ackAt !== 27) begin
         nFails++;
         $display("FAIL t6_ack_cycle: got %0d want 27", ackAt);
      end
      nChecks++;
      if ({bus.busy, bus.level} !== 5'b0) begin
         nFails++;
         $display("FAIL t6_end: busy/level got %b/%0d want 0/0", bus.busy, bus.level);
      end
   endtask

   initial begin
      test_reset();
      test_fill_transaction();
      test_drain_then_fill();
      test_arbitration();
      test_interlock();
      test_reset_mid();
      test_drop_request();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
